// File: rtl/rptr_empty_fwft.sv
// Read-side pointer/empty/level control for the dual-clock FIFO, with a first-word-fall-through output register.
// A word needs one edge to clear rempty and one more to reach rdata. rdata/rvalid hold while rvalid & ~rready.
module rptr_empty_fwft #(
    parameter int ADDRSIZE      = 4,
    parameter int DATASIZE      = 8,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rmem_data,
    input  logic                rready,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                rvalid,
    output logic [DATASIZE-1:0] rdata
);

    localparam logic [ADDRSIZE:0] AE_TH = AEMPTY_THRESH[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

    logic [ADDRSIZE:0] r_rbin;
    logic [ADDRSIZE:0] w_rbinnext;
    logic [ADDRSIZE:0] w_rgraynext;
    logic [ADDRSIZE:0] w_wbin_s;
    logic [ADDRSIZE:0] w_diff;
    logic              w_mem_pop;

    // Refill the output register whenever it is empty or being drained this cycle.
    assign w_mem_pop   = ~rempty & (~rvalid | rready);
    assign w_rbinnext  = r_rbin + {{ADDRSIZE{1'b0}}, w_mem_pop};
    assign w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;
    assign raddr       = r_rbin[ADDRSIZE-1:0];

    always_comb begin
        w_wbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            w_wbin_s[i] = ^(rq2_wptr >> i);
        end
    end

    assign w_diff = w_wbin_s - w_rbinnext;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin  <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b1;
            rlevel  <= '0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            r_rbin  <= w_rbinnext;
            rptr    <= w_rgraynext;
            rempty  <= (w_rgraynext == rq2_wptr);
            rlevel  <= w_diff;
            raempty <= (w_diff <= AE_TH);
            if (w_mem_pop) begin
                rdata  <= rmem_data;
                rvalid <= 1'b1;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // A larger gap means the write side overran wfull.
    a_diff_bound: assert property (@(posedge rclk) disable iff (!rrst_n) w_diff <= DEPTH)
        else $error("rptr_empty_fwft: write pointer more than depth ahead of read pointer");

endmodule
